// File: rtl/saturn_inst_decoder_q_pkg.sv
// Shared encodings for the queued Saturn instruction decoder.
// Instruction types, ALU register/opcode codes, FSM states, immediate lengths.
// Pure definitions; no logic.
package saturn_inst_decoder_q_pkg;

  // Instruction type codes presented to the execution unit
  localparam logic [3:0] INSTR_TYPE_ALU      = 4'd0;
  localparam logic [3:0] INSTR_TYPE_LOAD     = 4'd1;
  localparam logic [3:0] INSTR_TYPE_JUMP     = 4'd2;
  localparam logic [3:0] INSTR_TYPE_SET_MODE = 4'd3;
  localparam logic [3:0] INSTR_TYPE_RESET    = 4'd4;
  localparam logic [3:0] INSTR_TYPE_NONE     = 4'd15;

  // ALU register selectors
  localparam logic [4:0] ALU_REG_A    = 5'd0;
  localparam logic [4:0] ALU_REG_B    = 5'd1;
  localparam logic [4:0] ALU_REG_C    = 5'd2;
  localparam logic [4:0] ALU_REG_D    = 5'd3;
  localparam logic [4:0] ALU_REG_P    = 5'd8;
  localparam logic [4:0] ALU_REG_ST   = 5'd9;
  localparam logic [4:0] ALU_REG_HST  = 5'd10;
  localparam logic [4:0] ALU_REG_IMM  = 5'd12;
  localparam logic [4:0] ALU_REG_NONE = 5'd31;

  // ALU operations
  localparam logic [4:0] ALU_OP_COPY     = 5'd0;
  localparam logic [4:0] ALU_OP_CLR_MASK = 5'd4;
  localparam logic [4:0] ALU_OP_NOP      = 5'd31;

  // Immediate lengths of the jump families
  localparam logic [4:0] IMM_LEN_JUMP3 = 5'd3;
  localparam logic [4:0] IMM_LEN_JUMP5 = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREFIX = 3'd1,
    ST_IMM    = 3'd2,
    ST_EMIT   = 3'd3,
    ST_ERROR  = 3'd4
  } dec_state_t;

  // Decoded instruction fields other than the immediate payload
  typedef struct packed {
    logic [3:0] itype;
    logic [4:0] dest;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [3:0] ptr_begin;
    logic [3:0] ptr_end;
    logic [4:0] opcode;
    logic       push_pc;
  } instr_fields_t;

  function automatic instr_fields_t fields_none();
    instr_fields_t f;
    f.itype     = INSTR_TYPE_NONE;
    f.dest      = ALU_REG_NONE;
    f.src1      = ALU_REG_NONE;
    f.src2      = ALU_REG_NONE;
    f.ptr_begin = 4'd0;
    f.ptr_end   = 4'd0;
    f.opcode    = ALU_OP_NOP;
    f.push_pc   = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/saturn_inst_decoder_q_fifo.sv
// Nibble prefetch queue: DEPTH entries of WIDTH bits, circular buffer.
// Latency: an entry pushed at edge N is poppable from edge N+1 (registered count).
// Backpressure: full blocks push, empty blocks pop; clear empties the queue and wins over push.
module saturn_nibble_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; written only on accepted pushes
  always_ff @(posedge clk) begin
    if (en && do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/saturn_inst_decoder_q.sv
// Saturn decoder with nibble prefetch queue; packs each instruction into one transaction.
// Latency: valid the cycle after the last nibble of an instruction pops from the queue.
// Backpressure: payload held while i_instr_ready is low; queue fills and drops o_nib_ready.
module saturn_inst_decoder_q
  import saturn_inst_decoder_q_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int ADDR_W       = 20,
  parameter int MAX_IMM_NIBS = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_clk_en,
  input  logic                      i_flush,
  input  logic                      i_nib_valid,
  input  logic [3:0]                i_nibble,
  input  logic [ADDR_W-1:0]         i_nib_pc,
  output logic                      o_nib_ready,
  input  logic [3:0]                i_reg_p,
  output logic                      o_instr_valid,
  input  logic                      i_instr_ready,
  output logic [ADDR_W-1:0]         o_instr_pc,
  output logic [3:0]                o_instr_type,
  output logic [4:0]                o_alu_reg_dest,
  output logic [4:0]                o_alu_reg_src_1,
  output logic [4:0]                o_alu_reg_src_2,
  output logic [3:0]                o_alu_ptr_begin,
  output logic [3:0]                o_alu_ptr_end,
  output logic [4:0]                o_alu_opcode,
  output logic [4*MAX_IMM_NIBS-1:0] o_imm_data,
  output logic [4:0]                o_imm_len,
  output logic                      o_push_pc,
  output logic                      o_decoder_error
);

  localparam int IW = 4 * MAX_IMM_NIBS;

  logic [ADDR_W+3:0] fifo_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              flush;
  logic [3:0]        nib;
  logic [ADDR_W-1:0] nib_pc;

  dec_state_t        state_q, state_d;
  instr_fields_t     fields_q, fields_d;
  logic [IW-1:0]     imm_q, imm_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        pfx0_q, pfx0_d;
  logic [3:0]        pfx1_q, pfx1_d;
  logic [1:0]        pfxc_q, pfxc_d;
  logic              err_q;

  assign flush  = i_flush && i_clk_en;
  assign nib    = fifo_dat[3:0];
  assign nib_pc = fifo_dat[ADDR_W+3:4];

  saturn_nibble_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ADDR_W + 4)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .en        (i_clk_en),
    .clear     (i_flush),
    .push      (i_nib_valid),
    .push_data ({i_nib_pc, i_nibble}),
    .pop       (pop),
    .pop_data  (fifo_dat),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state decode: consumes at most one queued nibble per cycle
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    imm_d    = imm_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    pfx0_d   = pfx0_q;
    pfx1_d   = pfx1_q;
    pfxc_d   = pfxc_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        pc_d     = nib_pc;
        fields_d = fields_none();
        imm_d    = '0;
        len_d    = 5'd0;
        cnt_d    = 5'd0;
        pfx0_d   = nib;
        pfxc_d   = 2'd0;
        case (nib)
          4'h0, 4'h8: state_d = ST_PREFIX;
          4'h2: begin
            // P=n: the n nibble is collected as a one-nibble immediate
            fields_d.itype  = INSTR_TYPE_ALU;
            fields_d.dest   = ALU_REG_P;
            fields_d.src1   = ALU_REG_IMM;
            fields_d.opcode = ALU_OP_COPY;
            len_d           = 5'd1;
            state_d         = ST_IMM;
          end
          4'h3: begin
            // LC: length nibble still pending, marked by len = 0
            fields_d.itype     = INSTR_TYPE_LOAD;
            fields_d.dest      = ALU_REG_C;
            fields_d.ptr_begin = i_reg_p;
            state_d            = ST_IMM;
          end
          4'h6, 4'h7: begin
            fields_d.itype   = INSTR_TYPE_JUMP;
            fields_d.push_pc = nib[0];
            len_d            = IMM_LEN_JUMP3;
            state_d          = ST_IMM;
          end
          default: state_d = ST_ERROR;
        endcase
      end
      ST_PREFIX: if (!fifo_empty) begin
        pop = 1'b1;
        if (pfx0_q == 4'h0) begin
          if (nib == 4'h4 || nib == 4'h5) begin
            fields_d.itype = INSTR_TYPE_SET_MODE;
            imm_d[3:0]     = {3'b000, nib[0]};
            len_d          = 5'd1;
            state_d        = ST_EMIT;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (pfxc_q == 2'd0) begin
          pfx1_d = nib;
          pfxc_d = 2'd1;
          case (nib)
            4'h0, 4'h2, 4'h4, 4'h5: state_d = ST_PREFIX;
            4'hD, 4'hF: begin
              fields_d.itype   = INSTR_TYPE_JUMP;
              fields_d.push_pc = (nib == 4'hF);
              len_d            = IMM_LEN_JUMP5;
              state_d          = ST_IMM;
            end
            default: state_d = ST_ERROR;
          endcase
        end else if (pfxc_q == 2'd1) begin
          case (pfx1_q)
            4'h0: begin
              if (nib == 4'hA) begin
                fields_d.itype = INSTR_TYPE_RESET;
                state_d        = ST_EMIT;
              end else if (nib == 4'hC) begin
                pfxc_d = 2'd2;
              end else begin
                state_d = ST_ERROR;
              end
            end
            4'h2: begin
              fields_d.itype  = INSTR_TYPE_ALU;
              fields_d.dest   = ALU_REG_HST;
              fields_d.src1   = ALU_REG_IMM;
              fields_d.opcode = ALU_OP_CLR_MASK;
              imm_d[3:0]      = nib;
              len_d           = 5'd1;
              state_d         = ST_EMIT;
            end
            4'h4, 4'h5: begin
              fields_d.itype     = INSTR_TYPE_ALU;
              fields_d.dest      = ALU_REG_ST;
              fields_d.src1      = ALU_REG_IMM;
              fields_d.opcode    = ALU_OP_COPY;
              fields_d.ptr_begin = nib;
              fields_d.ptr_end   = nib;
              imm_d[3:0]         = {3'b000, pfx1_q[0]};
              len_d              = 5'd1;
              state_d            = ST_EMIT;
            end
            default: state_d = ST_ERROR;
          endcase
        end else begin
          // 80Cn: C=P n
          fields_d.itype     = INSTR_TYPE_ALU;
          fields_d.dest      = ALU_REG_C;
          fields_d.src1      = ALU_REG_P;
          fields_d.opcode    = ALU_OP_COPY;
          fields_d.ptr_begin = nib;
          fields_d.ptr_end   = nib;
          state_d            = ST_EMIT;
        end
      end
      ST_IMM: if (!fifo_empty) begin
        pop = 1'b1;
        if (len_q == 5'd0) begin
          len_d            = 5'(nib) + 5'd1;
          fields_d.ptr_end = fields_q.ptr_begin + nib;
        end else begin
          if (int'(cnt_q) < MAX_IMM_NIBS) imm_d[{cnt_q, 2'b00} +: 4] = nib;
          cnt_d = cnt_q + 5'd1;
          if ((cnt_q + 5'd1) == len_q) state_d = ST_EMIT;
        end
      end
      ST_EMIT: if (i_instr_ready) state_d = ST_IDLE;
      default: state_d = ST_ERROR;
    endcase
  end

  // Decoder registers; flush discards partial work but leaves ERROR in place
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      fields_q <= fields_none();
      imm_q    <= '0;
      len_q    <= 5'd0;
      cnt_q    <= 5'd0;
      pc_q     <= '0;
      pfx0_q   <= 4'd0;
      pfx1_q   <= 4'd0;
      pfxc_q   <= 2'd0;
      err_q    <= 1'b0;
    end else if (i_clk_en) begin
      if (flush) begin
        state_q  <= (state_q == ST_ERROR) ? ST_ERROR : ST_IDLE;
        fields_q <= fields_none();
        imm_q    <= '0;
        len_q    <= 5'd0;
        cnt_q    <= 5'd0;
        pc_q     <= '0;
        pfxc_q   <= 2'd0;
      end else begin
        state_q  <= state_d;
        fields_q <= fields_d;
        imm_q    <= imm_d;
        len_q    <= len_d;
        cnt_q    <= cnt_d;
        pc_q     <= pc_d;
        pfx0_q   <= pfx0_d;
        pfx1_q   <= pfx1_d;
        pfxc_q   <= pfxc_d;
        err_q    <= err_q | (state_d == ST_ERROR);
      end
    end
  end

  assign o_nib_ready     = !fifo_full;
  assign o_instr_valid   = (state_q == ST_EMIT);
  assign o_instr_pc      = pc_q;
  assign o_instr_type    = fields_q.itype;
  assign o_alu_reg_dest  = fields_q.dest;
  assign o_alu_reg_src_1 = fields_q.src1;
  assign o_alu_reg_src_2 = fields_q.src2;
  assign o_alu_ptr_begin = fields_q.ptr_begin;
  assign o_alu_ptr_end   = fields_q.ptr_end;
  assign o_alu_opcode    = fields_q.opcode;
  assign o_imm_data      = imm_q;
  assign o_imm_len       = len_q;
  assign o_push_pc       = fields_q.push_pc;
  assign o_decoder_error = err_q;

endmodule
